// File: rtl/washer_pkg.sv
// Shared types for the washing-machine sequencer.
//   state_t       : controller phase, 4-bit encoding
//   OB_*          : bit positions inside the decoded actuator/indicator vector
//   is_locked()   : phases that hold the door lock
//   is_watched()  : fill/drain phases supervised by the watchdog
package washer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FILL_W = 4'd1,
      ST_WASH   = 4'd2,
      ST_DRAIN  = 4'd3,
      ST_FILL_R = 4'd4,
      ST_RINSE  = 4'd5,
      ST_SPIN   = 4'd6,
      ST_DONE   = 4'd7,
      ST_FAULT  = 4'd8
   } state_t;

   localparam int unsigned OB_LOCK  = 0;
   localparam int unsigned OB_MOTOR = 1;
   localparam int unsigned OB_FILL  = 2;
   localparam int unsigned OB_DRAIN = 3;
   localparam int unsigned OB_SOAP  = 4;
   localparam int unsigned OB_WATER = 5;
   localparam int unsigned OB_DONE  = 6;
   localparam int unsigned OB_FAULT = 7;
   localparam int unsigned OB_W     = 8;

   function automatic logic is_locked(state_t s);
      return s inside {ST_FILL_W, ST_WASH, ST_DRAIN, ST_FILL_R, ST_RINSE, ST_SPIN};
   endfunction

   function automatic logic is_watched(state_t s);
      return s inside {ST_FILL_W, ST_DRAIN, ST_FILL_R};
   endfunction

endpackage

// File: rtl/washer_ctrl_param_if.sv
// Panel/sensor inputs and actuator/indicator outputs of one washing machine.
//   master : front panel + sensors side (drives inputs, reads actuators)
//   slave  : sequencer side
interface washer_ctrl_param_if;
   logic       start;
   logic       door_close;
   logic       filled;
   logic       detergent_added;
   logic       drained;
   logic       pause;
   logic       fault_clr;
   logic       door_lock;
   logic       motor_on;
   logic       fill_valve_on;
   logic       drain_valve_on;
   logic       soap_wash;
   logic       water_wash;
   logic       done;
   logic       fault;
   logic [3:0] rinse_left;

   modport master (
      output start, door_close, filled, detergent_added, drained, pause, fault_clr,
      input  door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
             water_wash, done, fault, rinse_left
   );

   modport slave (
      input  start, door_close, filled, detergent_added, drained, pause, fault_clr,
      output door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
             water_wash, done, fault, rinse_left
   );
endinterface

// File: rtl/washer_timer.sv
// Loadable TW-bit down-counter used for phase durations and the watchdog.
//   clk, reset  : clock, async active-low reset
//   i_load      : load i_load_val (wins over counting)
//   i_en        : count down by one when nonzero
//   o_zero      : counter is zero
module washer_timer #(
   parameter int unsigned TW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_load,
   input  logic [TW-1:0] i_load_val,
   input  logic          i_en,
   output logic          o_zero
);

   logic [TW-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    r_cnt <= '0;
      else if (i_load)               r_cnt <= i_load_val;
      else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - TW'(1);
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/washer_ctrl_param.sv
// Parametrised washing-machine sequencer (Moore FSM).
//   clk, reset : clock, async active-low reset
//   bus        : panel/sensor inputs and valve/motor/lock/indicator outputs
// Programme: FILL_W, WASH, DRAIN, (FILL_R, RINSE, DRAIN) x RINSE_COUNT, SPIN, DONE.
// Open door while locked or a fill/drain watchdog expiry forces FAULT.
import washer_pkg::*;

module washer_ctrl_param #(
   parameter int unsigned TW          = 8,
   parameter int unsigned WASH_TICKS  = 20,
   parameter int unsigned RINSE_TICKS = 10,
   parameter int unsigned SPIN_TICKS  = 15,
   parameter int unsigned RINSE_COUNT = 2,
   parameter int unsigned FILL_LIMIT  = 50,
   parameter int unsigned DRAIN_LIMIT = 50
) (
   input logic                clk,
   input logic                reset,
   washer_ctrl_param_if.slave bus
);

   state_t          r_state;
   state_t          w_next;
   logic [3:0]      r_rinse_left;
   logic [OB_W-1:0] w_out;
   logic            w_entry;
   logic            w_ph_load, w_wd_load;
   logic [TW-1:0]   w_ph_val, w_wd_val;
   logic            w_ph_zero, w_wd_zero;
   logic            w_en;

   assign w_en = !bus.pause;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next state: door fault, then watchdog, then pause hold, then programme flow
   always_comb begin
      w_next = r_state;
      if (is_locked(r_state) && !bus.door_close) begin
         w_next = ST_FAULT;
      end else if (is_watched(r_state) && w_wd_zero && !bus.pause) begin
         w_next = ST_FAULT;
      end else if (is_locked(r_state) && bus.pause) begin
         w_next = r_state;
      end else begin
         case (r_state)
            ST_IDLE:   if (bus.start && bus.door_close)        w_next = ST_FILL_W;
            ST_FILL_W: if (bus.filled && bus.detergent_added)  w_next = ST_WASH;
            ST_WASH:   if (w_ph_zero)                          w_next = ST_DRAIN;
            ST_DRAIN:  if (bus.drained)
                          w_next = (r_rinse_left != '0) ? ST_FILL_R : ST_SPIN;
            ST_FILL_R: if (bus.filled)                         w_next = ST_RINSE;
            ST_RINSE:  if (w_ph_zero)                          w_next = ST_DRAIN;
            ST_SPIN:   if (w_ph_zero)                          w_next = ST_DONE;
            ST_DONE:   if (!bus.start)                         w_next = ST_IDLE;
            ST_FAULT:  if (bus.fault_clr)                      w_next = ST_IDLE;
            default:                                           w_next = ST_IDLE;
         endcase
      end
   end

   // Timers load N-1 on the edge that enters their phase, so a phase lasts N active cycles
   always_comb begin
      w_entry   = (w_next != r_state);
      w_ph_load = w_entry && (w_next inside {ST_WASH, ST_RINSE, ST_SPIN});
      w_wd_load = w_entry && is_watched(w_next);
      case (w_next)
         ST_WASH:  w_ph_val = TW'(WASH_TICKS - 1);
         ST_RINSE: w_ph_val = TW'(RINSE_TICKS - 1);
         default:  w_ph_val = TW'(SPIN_TICKS - 1);
      endcase
      w_wd_val = (w_next == ST_DRAIN) ? TW'(DRAIN_LIMIT - 1) : TW'(FILL_LIMIT - 1);
   end

   washer_timer #(.TW(TW)) u_phase_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_ph_load),
      .i_load_val (w_ph_val),
      .i_en       (w_en),
      .o_zero     (w_ph_zero)
   );

   washer_timer #(.TW(TW)) u_watchdog (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_wd_load),
      .i_load_val (w_wd_val),
      .i_en       (w_en),
      .o_zero     (w_wd_zero)
   );

   // Rinse passes: armed leaving WASH, decremented leaving each RINSE, cleared back in IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                       r_rinse_left <= '0;
      else if (w_next == ST_IDLE)                       r_rinse_left <= '0;
      else if (r_state == ST_WASH  && w_next == ST_DRAIN) r_rinse_left <= 4'(RINSE_COUNT);
      else if (r_state == ST_RINSE && w_next == ST_DRAIN) r_rinse_left <= r_rinse_left - 4'd1;
   end

   // Output decode; pause only silences actuators in the locked phases
   always_comb begin
      w_out = '0;
      case (r_state)
         ST_FILL_W, ST_FILL_R: begin w_out[OB_LOCK] = 1'b1; w_out[OB_FILL] = 1'b1; end
         ST_WASH:  begin w_out[OB_LOCK] = 1'b1; w_out[OB_MOTOR] = 1'b1; w_out[OB_SOAP]  = 1'b1; end
         ST_RINSE: begin w_out[OB_LOCK] = 1'b1; w_out[OB_MOTOR] = 1'b1; w_out[OB_WATER] = 1'b1; end
         ST_DRAIN: begin w_out[OB_LOCK] = 1'b1; w_out[OB_DRAIN] = 1'b1; end
         ST_SPIN:  begin w_out[OB_LOCK] = 1'b1; w_out[OB_MOTOR] = 1'b1; w_out[OB_DRAIN] = 1'b1; end
         ST_DONE:  w_out[OB_DONE] = 1'b1;
         ST_FAULT: begin w_out[OB_FAULT] = 1'b1; w_out[OB_DRAIN] = 1'b1; end
         default:  w_out = '0;
      endcase
      if (is_locked(r_state) && bus.pause) begin
         w_out[OB_MOTOR] = 1'b0;
         w_out[OB_FILL]  = 1'b0;
         w_out[OB_DRAIN] = 1'b0;
      end
   end

   assign bus.door_lock      = w_out[OB_LOCK];
   assign bus.motor_on       = w_out[OB_MOTOR];
   assign bus.fill_valve_on  = w_out[OB_FILL];
   assign bus.drain_valve_on = w_out[OB_DRAIN];
   assign bus.soap_wash      = w_out[OB_SOAP];
   assign bus.water_wash     = w_out[OB_WATER];
   assign bus.done           = w_out[OB_DONE];
   assign bus.fault          = w_out[OB_FAULT];
   assign bus.rinse_left     = r_rinse_left;

endmodule

// File: doc/washer_ctrl_param.md
Name: washer_ctrl_param

Overview:
Parametrised washing-machine sequencer. Internal tick timers replace the external cycle/spin timeout inputs. Adds a configurable number of rinse passes, pause, and a fault state for fill/drain timeouts and door-open-while-locked. Sits between the front-panel/sensor inputs and the valve/motor/lock actuators; one instance per machine.

Parameters:
TW, 8, timer/counter width in bits
WASH_TICKS, 20, soap-wash duration in clk cycles (1..2^TW-1)
RINSE_TICKS, 10, duration of each rinse in clk cycles (1..2^TW-1)
SPIN_TICKS, 15, final spin duration in clk cycles (1..2^TW-1)
RINSE_COUNT, 2, number of rinse passes (1..15)
FILL_LIMIT, 50, maximum cycles allowed in a fill state before fault
DRAIN_LIMIT, 50, maximum cycles allowed in a drain state before fault

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  level; request to run a programme
door_close  in  1  door sensor, 1 = closed
filled  in  1  water-level-full sensor
detergent_added  in  1  detergent-present sensor
drained  in  1  drum-empty sensor
pause  in  1  level; freezes the programme
fault_clr  in  1  pulse; leave FAULT
door_lock  out  1  door lock solenoid
motor_on  out  1  drum motor
fill_valve_on  out  1  inlet valve
drain_valve_on  out  1  drain valve
soap_wash  out  1  soap-wash phase indicator
water_wash  out  1  rinse phase indicator
done  out  1  programme complete
fault  out  1  fault indicator
rinse_left  out  4  rinse passes remaining

Behaviour:
- Moore machine. Outputs decode from the registered state only. The state register and counters reset asynchronously when reset = 0.
- Reset values: state = IDLE. All outputs = 0. rinse_left = 0.
- States and transitions (evaluated each rising edge):
  - IDLE: if start && door_close -> FILL_W.
  - FILL_W: lock=1, fill=1. If filled && detergent_added -> WASH.
  - WASH: lock=1, motor=1, soap_wash=1. After WASH_TICKS active cycles -> DRAIN. On entering DRAIN, rinse_left = RINSE_COUNT.
  - DRAIN: lock=1, drain=1. If drained: rinse_left != 0 -> FILL_R; rinse_left == 0 -> SPIN.
  - FILL_R: lock=1, fill=1. If filled -> RINSE.
  - RINSE: lock=1, motor=1, water_wash=1. After RINSE_TICKS active cycles -> DRAIN, and rinse_left decrements by 1.
  - SPIN: lock=1, motor=1, drain=1. After SPIN_TICKS active cycles -> DONE.
  - DONE: done=1, lock=0. If !start -> IDLE. Holding start high never restarts a programme.
  - FAULT: fault=1, drain=1, lock=0, motor=0. If fault_clr -> IDLE.
- Timer behaviour:
  - The timer loads N-1 on entry to a timed state and counts down.
  - The exit transition happens on the edge where timer == 0 and pause == 0.
  - The timed state therefore lasts exactly N cycles when pause is never asserted.
- Pause:
  - Applies only in FILL_W, WASH, DRAIN, FILL_R, RINSE and SPIN.
  - Freezes the state and all timers.
  - Forces motor, fill and drain outputs to 0; door_lock stays 1.
  - Ignored in IDLE, DONE and FAULT.
- Watchdog:
  - Separate counter; clears on entry to any fill or drain state and counts unpaused cycles.
  - FILL_LIMIT cycles in FILL_W/FILL_R, or DRAIN_LIMIT cycles in DRAIN, without the exit condition -> FAULT.
- Door: door_close == 0 in any state with lock=1 -> FAULT on that edge. This takes priority over every other transition.
- Priority (highest first): reset, door fault, watchdog fault, pause, normal transition.
- If start falls mid-programme, the programme continues. Only DONE samples !start.
- Reset mid-programme: immediate IDLE with all outputs at 0, including door_lock.

Decomposition:
- Package washer_pkg holds:
  - the state enum (IDLE, FILL_W, WASH, DRAIN, FILL_R, RINSE, SPIN, DONE, FAULT; 4-bit encoding);
  - output-vector bit positions.
- One sub-module, washer_timer: TW-bit loadable down-counter with load, enable (= !pause) and zero flag.
  - Instantiated twice: once as the phase timer, once as the watchdog.

Test Plan:
1. Nominal programme (WASH_TICKS=4, RINSE_TICKS=3, SPIN_TICKS=5, RINSE_COUNT=2). Release reset, start=1, door_close=1, then filled, detergent_added and drained driven as each phase requests. Required response:
   - phase order FILL_W, WASH(4), DRAIN, FILL_R, RINSE(3), DRAIN, FILL_R, RINSE(3), DRAIN, SPIN(5), DONE;
   - rinse_left sequence 2, 1, 0;
   - done=1 and door_lock=0 at the end.
2. Pause in WASH after 2 cycles, held for 6 cycles. Required: motor_on=0 for those 6 cycles and door_lock stays 1. WASH totals 4 unpaused cycles, for 10 cycles in WASH overall.
3. door_close=0 during RINSE. Required: FAULT on the next edge with fault=1, drain_valve_on=1, door_lock=0. A fault_clr pulse returns the machine to IDLE with all outputs 0.
4. Fill timeout (FILL_LIMIT=8): hold filled=0 in FILL_W. Required: FAULT after 8 cycles. With filled=1 at cycle 7, WASH is entered and no fault occurs.
5. start held at 1 in DONE. Required: the machine stays in DONE with no restart. After start=0 it enters IDLE; start=1 then begins FILL_W.
6. Reset asserted (0) during SPIN. Required: outputs drop to 0 immediately, asynchronously. The machine is in IDLE after reset is released.
